// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo-12 counter checker.
package counter_pkg;

  localparam int MOD = 12;

  typedef logic [3:0] count_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } chk_state_t;

  // A count value is legal only inside the 0..MOD-1 range.
  function automatic logic is_legal(input count_t v);
    return v < count_t'(MOD);
  endfunction

endpackage

// File: rtl/mod12_next_val.sv
// Next value of a modulo-12 up/down counter with synchronous load.
module mod12_next_val
  import counter_pkg::*;
(
  input  logic [3:0] cur,
  input  logic       load,
  input  logic       mode,
  input  logic [3:0] data_in,
  output logic [3:0] nxt
);

  // Load wins over direction, exactly as the counter under check resolves it.
  always_comb begin
    nxt = cur;
    if (load) begin
      nxt = data_in;
    end else if (mode) begin
      nxt = (cur == count_t'(MOD - 1)) ? 4'd0 : cur + 4'd1;
    end else begin
      nxt = (cur == 4'd0) ? count_t'(MOD - 1) : cur - 4'd1;
    end
  end

endmodule

// File: rtl/mod12_count_checker.sv
// Observes a modulo-12 counter, tracks its expected value and reports
// mismatches, illegal loads and running statistics.
module mod12_count_checker
  import counter_pkg::*;
#(
  parameter int MAX_ERR     = 15,
  parameter int STOP_ON_ERR = 0
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        chk_en,
  input  logic        load,
  input  logic        mode,
  input  logic [3:0]  data_in,
  input  logic [3:0]  count,
  output logic        mismatch,
  output logic        illegal_load,
  output logic [7:0]  err_cnt,
  output logic [15:0] chk_cnt,
  output logic        first_err_vld,
  output logic [3:0]  first_err_exp,
  output logic [3:0]  first_err_act,
  output logic        halted
);

  localparam logic [7:0] MAX_ERR_C = 8'(MAX_ERR);

  chk_state_t state_reg, state_next;
  count_t     exp_reg, exp_next;
  logic       mismatch_reg, mismatch_next;
  logic       illegal_reg, illegal_next;
  logic [7:0] err_cnt_reg, err_cnt_next;
  logic [15:0] chk_cnt_reg, chk_cnt_next;
  logic       fev_reg, fev_next;
  count_t     fee_reg, fee_next;
  count_t     fea_reg, fea_next;

  count_t     model_nxt;
  count_t     resync_nxt;
  logic       compare;
  logic       fail;
  logic       ill;
  logic [7:0] err_inc;
  logic [15:0] chk_inc;

  // Free-running model path: expected value advances from its own history.
  mod12_next_val u_model_nv (
    .cur     (exp_reg),
    .load    (load),
    .mode    (mode),
    .data_in (data_in),
    .nxt     (model_nxt)
  );

  // Resync path: next value derived from what the counter actually shows.
  mod12_next_val u_resync_nv (
    .cur     (count),
    .load    (load),
    .mode    (mode),
    .data_in (data_in),
    .nxt     (resync_nxt)
  );

  always_comb begin
    compare = (state_reg == CHECK) && chk_en;
    fail    = compare && ((count != exp_reg) || !is_legal(count));
    ill     = load && !is_legal(data_in);
    err_inc = (err_cnt_reg == 8'hFF) ? 8'hFF : err_cnt_reg + 8'd1;
    chk_inc = (chk_cnt_reg == 16'hFFFF) ? 16'hFFFF : chk_cnt_reg + 16'd1;
  end

  always_comb begin
    state_next    = state_reg;
    exp_next      = exp_reg;
    mismatch_next = 1'b0;
    illegal_next  = 1'b0;
    err_cnt_next  = err_cnt_reg;
    chk_cnt_next  = chk_cnt_reg;
    fev_next      = fev_reg;
    fee_next      = fee_reg;
    fea_next      = fea_reg;

    case (state_reg)
      SYNC: begin
        exp_next     = resync_nxt;
        illegal_next = ill;
        state_next   = ill ? SYNC : CHECK;
      end

      CHECK: begin
        // A failure resyncs from the observed count so one fault yields one error.
        exp_next     = fail ? resync_nxt : model_nxt;
        illegal_next = ill;
        if (compare) begin
          chk_cnt_next = chk_inc;
        end
        if (fail) begin
          mismatch_next = 1'b1;
          err_cnt_next  = err_inc;
          if (!fev_reg) begin
            fev_next = 1'b1;
            fee_next = exp_reg;
            fea_next = count;
          end
        end
        if (ill) begin
          state_next = SYNC;
        end
        if ((STOP_ON_ERR != 0) && fail && (err_inc >= MAX_ERR_C)) begin
          state_next = HALT;
        end
      end

      HALT: begin
        state_next = HALT;
      end

      default: begin
        state_next = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= SYNC;
      exp_reg      <= '0;
      mismatch_reg <= 1'b0;
      illegal_reg  <= 1'b0;
      err_cnt_reg  <= '0;
      chk_cnt_reg  <= '0;
      fev_reg      <= 1'b0;
      fee_reg      <= '0;
      fea_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      exp_reg      <= exp_next;
      mismatch_reg <= mismatch_next;
      illegal_reg  <= illegal_next;
      err_cnt_reg  <= err_cnt_next;
      chk_cnt_reg  <= chk_cnt_next;
      fev_reg      <= fev_next;
      fee_reg      <= fee_next;
      fea_reg      <= fea_next;
    end
  end

  assign mismatch      = mismatch_reg;
  assign illegal_load  = illegal_reg;
  assign err_cnt       = err_cnt_reg;
  assign chk_cnt       = chk_cnt_reg;
  assign first_err_vld = fev_reg;
  assign first_err_exp = fee_reg;
  assign first_err_act = fea_reg;
  assign halted        = (state_reg == HALT);

endmodule

// File: tb/tb_mod12_count_checker.sv
// Scoreboard bench: a free-running checker and a stop-on-error checker watch
// the same bench-driven counter.
module tb_mod12_count_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       chk_en = 1'b0;
  logic       load = 1'b0;
  logic       mode = 1'b1;
  logic [3:0] data_in = 4'd0;
  logic [3:0] count = 4'd0;

  logic        mismatch, illegal_load, first_err_vld, halted;
  logic [7:0]  err_cnt;
  logic [15:0] chk_cnt;
  logic [3:0]  first_err_exp, first_err_act;

  logic        mismatch_h, illegal_load_h, first_err_vld_h, halted_h;
  logic [7:0]  err_cnt_h;
  logic [15:0] chk_cnt_h;
  logic [3:0]  first_err_exp_h, first_err_act_h;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic mis;
    logic ill;
  } exp_t;
  exp_t sb[$];

  logic [3:0] ctr = 4'd0;
  int         glitch = -1;

  always #5 clk = ~clk;

  mod12_count_checker #(.MAX_ERR(15), .STOP_ON_ERR(0)) dut (
    .clk(clk), .rst(rst), .chk_en(chk_en), .load(load), .mode(mode),
    .data_in(data_in), .count(count),
    .mismatch(mismatch), .illegal_load(illegal_load), .err_cnt(err_cnt),
    .chk_cnt(chk_cnt), .first_err_vld(first_err_vld),
    .first_err_exp(first_err_exp), .first_err_act(first_err_act),
    .halted(halted)
  );

  mod12_count_checker #(.MAX_ERR(3), .STOP_ON_ERR(1)) dut_h (
    .clk(clk), .rst(rst), .chk_en(chk_en), .load(load), .mode(mode),
    .data_in(data_in), .count(count),
    .mismatch(mismatch_h), .illegal_load(illegal_load_h), .err_cnt(err_cnt_h),
    .chk_cnt(chk_cnt_h), .first_err_vld(first_err_vld_h),
    .first_err_exp(first_err_exp_h), .first_err_act(first_err_act_h),
    .halted(halted_h)
  );

  task automatic check_val(input string tag, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, act, expv);
    end
  endtask

  // Behaviour of the counter under observation; illegal loads are rejected to 0.
  function automatic logic [3:0] ctr_next(input logic [3:0] c, input logic ld,
                                          input logic md, input logic [3:0] din);
    if (ld) return (din > 4'd11) ? 4'd0 : din;
    if (md) return (c == 4'd11) ? 4'd0 : c + 4'd1;
    return (c == 4'd0) ? 4'd11 : c - 4'd1;
  endfunction

  task automatic score();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val("mismatch", int'(mismatch), int'(e.mis));
      check_val("illegal_load", int'(illegal_load), int'(e.ill));
    end
  endtask

  task automatic drive(input logic ld, input logic md, input logic [3:0] din,
                       input logic en, input logic e_mis, input logic e_ill);
    exp_t e;
    @(negedge clk);
    score();
    load    = ld;
    mode    = md;
    data_in = din;
    chk_en  = en;
    count   = (glitch >= 0) ? 4'(glitch) : ctr;
    glitch  = -1;
    e.mis = e_mis;
    e.ill = e_ill;
    sb.push_back(e);
    $display("txn ld=%0d md=%0d din=%0d en=%0d count=%0d", ld, md, din, en, count);
    ctr = ctr_next(ctr, ld, md, din);
  endtask

  task automatic drain();
    @(negedge clk);
    score();
  endtask

  task automatic check_zero_outs(input string tag);
    check_val({tag, "_outs"}, int'({mismatch, illegal_load, err_cnt, first_err_vld,
                                    first_err_exp, first_err_act, halted}), 0);
    check_val({tag, "_chk_cnt"}, int'(chk_cnt), 0);
    check_val({tag, "_outs_h"}, int'({mismatch_h, illegal_load_h, err_cnt_h, first_err_vld_h,
                                      first_err_exp_h, first_err_act_h, halted_h}), 0);
    check_val({tag, "_chk_cnt_h"}, int'(chk_cnt_h), 0);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    load = 1'b0;
    chk_en = 1'b0;
    sb.delete();
    ctr = 4'd0;
    #2;
    check_zero_outs(tag);
    release_rst();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Load 5, then up-count against a correct counter.
    do_reset("reset1");
    drive(1, 1, 4'd5, 1, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 1, 4'd0, 1, 0, 0);
    drain();
    check_val("s1_err_cnt", int'(err_cnt), 0);
    check_val("s1_chk_cnt", int'(chk_cnt), 9);
    check_val("s1_first_vld", int'(first_err_vld), 0);

    // Down from 0 expects 11; counter shows 10 instead.
    do_reset("reset2");
    drive(1, 0, 4'd0, 1, 0, 0);
    drive(0, 0, 4'd0, 1, 0, 0);
    ctr = 4'd10;
    drive(0, 0, 4'd0, 1, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 4'd0, 1, 0, 0);
    drain();
    check_val("s2_err_cnt", int'(err_cnt), 1);
    check_val("s2_chk_cnt", int'(chk_cnt), 6);
    check_val("s2_first_vld", int'(first_err_vld), 1);
    check_val("s2_first_exp", int'(first_err_exp), 11);
    check_val("s2_first_act", int'(first_err_act), 10);

    // Illegal loads (12, 13) force SYNC; wrong count in SYNC is not an error.
    do_reset("reset3");
    drive(1, 1, 4'd11, 1, 0, 0);
    drive(0, 1, 4'd0, 1, 0, 0);
    drive(1, 1, 4'd12, 1, 0, 1);
    ctr = 4'd7;
    drive(0, 1, 4'd0, 1, 0, 0);
    drive(1, 1, 4'd13, 1, 0, 1);
    ctr = 4'd3;
    drive(0, 1, 4'd0, 1, 0, 0);
    drive(0, 1, 4'd0, 1, 0, 0);
    drive(0, 1, 4'd0, 1, 0, 0);
    drain();
    check_val("s3_err_cnt", int'(err_cnt), 0);
    check_val("s3_chk_cnt", int'(chk_cnt), 5);

    // chk_en low for 10 faulty cycles, then resume without resync.
    do_reset("reset4");
    drive(1, 1, 4'd2, 1, 0, 0);
    for (int i = 0; i < 2; i++) drive(0, 1, 4'd0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      glitch = (i % 2 == 0) ? 13 : int'((ctr + 4'd6) % 4'd12);
      drive(0, 1, 4'd0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) drive(0, 1, 4'd0, 1, 0, 0);
    ctr = (ctr + 4'd5) % 4'd12;
    drive(0, 1, 4'd0, 1, 1, 0);
    drive(0, 1, 4'd0, 1, 0, 0);
    drain();
    check_val("s4_err_cnt", int'(err_cnt), 1);
    check_val("s4_chk_cnt", int'(chk_cnt), 7);
    check_val("s4_first_exp", int'(first_err_exp), 5);
    check_val("s4_first_act", int'(first_err_act), 10);

    // Four faults: stop-on-error instance halts after the third.
    do_reset("reset5");
    drive(1, 1, 4'd0, 1, 0, 0);
    for (int f = 0; f < 4; f++) begin
      drive(0, 1, 4'd0, 1, 0, 0);
      drive(0, 1, 4'd0, 1, 0, 0);
      ctr = (ctr + 4'd5) % 4'd12;
      drive(0, 1, 4'd0, 1, 1, 0);
    end
    drain();
    check_val("s5_err_cnt", int'(err_cnt), 4);
    check_val("s5_chk_cnt", int'(chk_cnt), 12);
    check_val("s5_halted", int'(halted), 0);
    check_val("s5_first_exp", int'(first_err_exp), 2);
    check_val("s5_first_act", int'(first_err_act), 7);
    check_val("s5_h_halted", int'(halted_h), 1);
    check_val("s5_h_err_cnt", int'(err_cnt_h), 3);
    check_val("s5_h_chk_cnt", int'(chk_cnt_h), 9);
    check_val("s5_h_mismatch", int'(mismatch_h), 0);
    check_val("s5_h_first_vld", int'(first_err_vld_h), 1);
    check_val("s5_h_first_act", int'(first_err_act_h), 7);

    // Reset asserted mid-cycle while halted clears everything at once.
    #2 rst = 1'b1;
    #1;
    check_zero_outs("s6_halt_rst");
    load = 1'b0;
    chk_en = 1'b0;
    sb.delete();
    ctr = 4'd0;
    release_rst();
    drive(1, 1, 4'd4, 1, 0, 0);
    drive(0, 1, 4'd0, 1, 0, 0);
    drive(0, 1, 4'd0, 1, 0, 0);
    drain();
    check_val("s6_h_halted", int'(halted_h), 0);
    check_val("s6_h_chk_cnt", int'(chk_cnt_h), 2);
    check_val("s6_h_err_cnt", int'(err_cnt_h), 0);
    check_val("s6_h_mismatch", int'(mismatch_h), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
